snoop_bus_arbiter: RTL

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/mesi_types.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/snoop_bus_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/mesi_types.sv
// rtl/mesi_types.sv - shared snoop bus command and arbiter state types
package mesi_types;

    typedef enum logic [1:0] {
        No_OP   = 2'd0,
        BusRd   = 2'd1,
        BusRdX  = 2'd2,
        BusUpgr = 2'd3
    } bus_request;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner search starting at rr_ptr
module rr_arbiter #(
    parameter int NUM_CACHES = 4,
    localparam int IDX_W = $clog2(NUM_CACHES)
) (
    input  logic [NUM_CACHES-1:0] req,
    input  logic [IDX_W-1:0]      rr_ptr,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  grant_valid
);

    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(rr_ptr) + i) % NUM_CACHES);
            if (req[idx]) begin
                grant_idx   = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - round-robin snoop bus arbiter with hold timeout
module snoop_bus_arbiter
    import mesi_types::*;
#(
    parameter int NUM_CACHES = 4,
    parameter int ADDR_W     = 8,
    parameter int MAX_HOLD   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  bus_request            cmd_in   [NUM_CACHES],
    input  logic [ADDR_W-1:0]     bus_addr [NUM_CACHES],
    input  logic [NUM_CACHES-1:0] done_in,
    output bus_request            cmd_out,
    output logic [ADDR_W-1:0]     addr_out,
    output logic [NUM_CACHES-1:0] bus_owner,
    output logic                  bus_busy,
    output logic                  timeout_err
);

    localparam int IDX_W = $clog2(NUM_CACHES);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t            state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      next_ptr;
    logic                  grant_valid;
    logic [NUM_CACHES-1:0] req;
    logic [CNT_W-1:0]      hold_cnt;
    logic                  owner_done;
    logic                  hold_expired;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            req[i] = (cmd_in[i] != No_OP);
        end
    end

    rr_arbiter #(.NUM_CACHES(NUM_CACHES)) u_rr_arbiter (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // bus_owner is one-hot, so masking done_in with it isolates the owner's strobe.
    assign owner_done   = |(done_in & bus_owner);
    assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign next_ptr     = (grant_idx == IDX_W'(NUM_CACHES - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            cmd_out     <= No_OP;
            addr_out    <= '0;
            bus_owner   <= '0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        state     <= ARB_BUSY;
                        cmd_out   <= cmd_in[grant_idx];
                        addr_out  <= bus_addr[grant_idx];
                        bus_owner <= NUM_CACHES'(1) << grant_idx;
                        bus_busy  <= 1'b1;
                        hold_cnt  <= '0;
                        rr_ptr    <= next_ptr;
                    end else begin
                        cmd_out   <= No_OP;
                        addr_out  <= '0;
                        bus_owner <= '0;
                        bus_busy  <= 1'b0;
                    end
                end
                ARB_BUSY: begin
                    // A done arriving on the expiry cycle wins over the timeout.
                    if (owner_done || hold_expired) begin
                        state       <= ARB_IDLE;
                        cmd_out     <= No_OP;
                        addr_out    <= '0;
                        bus_owner   <= '0;
                        bus_busy    <= 1'b0;
                        hold_cnt    <= '0;
                        timeout_err <= !owner_done;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
